// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system command controller: frame opcodes,
// controller states and the fixed register-file slots used for ALU operands.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_RF_WR    = 8'hAA;
  localparam logic [7:0] CMD_RF_RD    = 8'hBB;
  localparam logic [7:0] CMD_ALU_OPR  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOPR = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    OPA,
    OPB,
    FUNC,
    ALU_WAIT,
    TX_LO,
    TX_HI
  } state_t;

endpackage

// File: rtl/sys_cmd_ctrl.sv
// System command controller: decodes UART command frames, drives register-file
// reads/writes and ALU starts, and returns results to the TX FIFO LSB first.
module sys_cmd_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUNC_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic [ADDR_WIDTH-1:0]   RF_ADDR,
  output logic                    RF_WR_EN,
  output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
  output logic                    RF_RD_EN,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_DATA_VLD,
  output logic                    CLK_GATE_EN,
  output logic                    ALU_EN,
  output logic [FUNC_WIDTH-1:0]   ALU_FUNC,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    TX_FULL
);

  state_t                  state, state_nxt;
  logic                    two_byte_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [2*DATA_WIDTH-1:0] result_q;

  // Next-state decode: byte-collecting states advance on RX_D_VLD, wait states on
  // the matching valid strobe, TX states only when the FIFO has room.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            CMD_RF_WR:    state_nxt = WR_ADDR;
            CMD_RF_RD:    state_nxt = RD_ADDR;
            CMD_ALU_OPR:  state_nxt = OPA;
            CMD_ALU_NOPR: state_nxt = FUNC;
            default:      state_nxt = IDLE;
          endcase
        end
      end
      WR_ADDR:  if (RX_D_VLD)       state_nxt = WR_DATA;
      WR_DATA:  if (RX_D_VLD)       state_nxt = IDLE;
      RD_ADDR:  if (RX_D_VLD)       state_nxt = RD_WAIT;
      RD_WAIT:  if (RF_RD_DATA_VLD) state_nxt = TX_LO;
      OPA:      if (RX_D_VLD)       state_nxt = OPB;
      OPB:      if (RX_D_VLD)       state_nxt = FUNC;
      FUNC:     if (RX_D_VLD)       state_nxt = ALU_WAIT;
      ALU_WAIT: if (ALU_OUT_VLD)    state_nxt = TX_LO;
      TX_LO:    if (!TX_FULL)       state_nxt = two_byte_q ? TX_HI : IDLE;
      TX_HI:    if (!TX_FULL)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // State register plus the response-length flag chosen by the wait state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      two_byte_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == RD_WAIT && RF_RD_DATA_VLD) two_byte_q <= 1'b0;
      if (state == ALU_WAIT && ALU_OUT_VLD)   two_byte_q <= 1'b1;
    end
  end

  // Data holding registers; contents are only consumed after being loaded.
  always_ff @(posedge CLK) begin
    if (state == WR_ADDR && RX_D_VLD) addr_q   <= RX_P_DATA[ADDR_WIDTH-1:0];
    if (state == RD_WAIT && RF_RD_DATA_VLD) result_q <= {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
    if (state == ALU_WAIT && ALU_OUT_VLD)   result_q <= ALU_OUT;
  end

  // Registered outputs: strobes default low each cycle, data buses hold their
  // last value; the clock gate stays open while an ALU operation is pending.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RF_ADDR     <= '0;
      RF_WR_EN    <= 1'b0;
      RF_WR_DATA  <= '0;
      RF_RD_EN    <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      ALU_EN      <= 1'b0;
      ALU_FUNC    <= '0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
    end else begin
      RF_WR_EN    <= 1'b0;
      RF_RD_EN    <= 1'b0;
      ALU_EN      <= 1'b0;
      TX_D_VLD    <= 1'b0;
      CLK_GATE_EN <= (state_nxt == FUNC) || (state_nxt == ALU_WAIT);
      case (state)
        WR_DATA: if (RX_D_VLD) begin
          RF_WR_EN   <= 1'b1;
          RF_ADDR    <= addr_q;
          RF_WR_DATA <= RX_P_DATA;
        end
        RD_ADDR: if (RX_D_VLD) begin
          RF_RD_EN <= 1'b1;
          RF_ADDR  <= RX_P_DATA[ADDR_WIDTH-1:0];
        end
        OPA: if (RX_D_VLD) begin
          RF_WR_EN   <= 1'b1;
          RF_ADDR    <= ADDR_WIDTH'(OPA_ADDR);
          RF_WR_DATA <= RX_P_DATA;
        end
        OPB: if (RX_D_VLD) begin
          RF_WR_EN   <= 1'b1;
          RF_ADDR    <= ADDR_WIDTH'(OPB_ADDR);
          RF_WR_DATA <= RX_P_DATA;
        end
        FUNC: if (RX_D_VLD) begin
          ALU_EN   <= 1'b1;
          ALU_FUNC <= RX_P_DATA[FUNC_WIDTH-1:0];
        end
        TX_LO: if (!TX_FULL) begin
          TX_D_VLD  <= 1'b1;
          TX_P_DATA <= result_q[DATA_WIDTH-1:0];
        end
        TX_HI: if (!TX_FULL) begin
          TX_D_VLD  <= 1'b1;
          TX_P_DATA <= result_q[2*DATA_WIDTH-1:DATA_WIDTH];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed bench for sys_cmd_ctrl: command frames with hand-computed results.
module tb_sys_cmd_ctrl;

  logic        CLK;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [3:0]  RF_ADDR;
  logic        RF_WR_EN;
  logic [7:0]  RF_WR_DATA;
  logic        RF_RD_EN;
  logic [7:0]  RF_RD_DATA;
  logic        RF_RD_DATA_VLD;
  logic        CLK_GATE_EN;
  logic        ALU_EN;
  logic [3:0]  ALU_FUNC;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_FULL;

  int errors = 0;
  int checks = 0;
  int tx_cnt = 0;
  int wr_cnt = 0;
  int viol   = 0;

  sys_cmd_ctrl dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_ADDR(RF_ADDR), .RF_WR_EN(RF_WR_EN), .RF_WR_DATA(RF_WR_DATA),
    .RF_RD_EN(RF_RD_EN), .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
    .CLK_GATE_EN(CLK_GATE_EN), .ALU_EN(ALU_EN), .ALU_FUNC(ALU_FUNC),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_FULL(TX_FULL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Strobe counters sampled on the falling edge.
  always @(negedge CLK) begin
    if (TX_D_VLD) tx_cnt++;
    if (RF_WR_EN) wr_cnt++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0;
    RF_RD_DATA = '0; RF_RD_DATA_VLD = 1'b0;
    ALU_OUT = '0; ALU_OUT_VLD = 1'b0; TX_FULL = 1'b0;
    repeat (3) tick();
    chk("rst_outputs", {RF_WR_EN, RF_RD_EN, ALU_EN, TX_D_VLD, CLK_GATE_EN}, 0);
    chk("rst_buses", {RF_ADDR, RF_WR_DATA, ALU_FUNC, TX_P_DATA}, 0);
    RST = 1'b1;
    tick();

    // Register write 0xA6 @ 5
    tx_cnt = 0; wr_cnt = 0;
    send(8'hAA); send(8'h05); send(8'hA6);
    chk("wr_en", 32'(RF_WR_EN), 1);
    chk("wr_addr", 32'(RF_ADDR), 'h5);
    chk("wr_data", 32'(RF_WR_DATA), 'hA6);
    tick();
    chk("wr_en_off", 32'(RF_WR_EN), 0);
    chk("wr_data_hold", 32'(RF_WR_DATA), 'hA6);
    repeat (3) tick();
    chk("wr_count", 32'(wr_cnt), 1);
    chk("wr_no_tx", 32'(tx_cnt), 0);

    // Register read @ 5 returning 0xA6
    tx_cnt = 0;
    send(8'hBB); send(8'h05);
    chk("rd_en", 32'(RF_RD_EN), 1);
    chk("rd_addr", 32'(RF_ADDR), 'h5);
    tick();
    chk("rd_en_off", 32'(RF_RD_EN), 0);
    RF_RD_DATA = 8'hA6; RF_RD_DATA_VLD = 1'b1;
    tick();
    RF_RD_DATA_VLD = 1'b0;
    tick();
    chk("rd_tx_vld", 32'(TX_D_VLD), 1);
    chk("rd_tx_data", 32'(TX_P_DATA), 'hA6);
    tick();
    chk("rd_tx_off", 32'(TX_D_VLD), 0);
    repeat (3) tick();
    chk("rd_tx_count", 32'(tx_cnt), 1);

    // ALU op with operands 0x28, 0x1E, func 1, result 0x000A
    tx_cnt = 0;
    send(8'hCC);
    send(8'h28);
    chk("opa_wr", {RF_WR_EN, RF_ADDR, RF_WR_DATA}, {1'b1, 4'h0, 8'h28});
    send(8'h1E);
    chk("opb_wr", {RF_WR_EN, RF_ADDR, RF_WR_DATA}, {1'b1, 4'h1, 8'h1E});
    chk("cg_on_func", 32'(CLK_GATE_EN), 1);
    send(8'h01);
    chk("alu_en", {ALU_EN, ALU_FUNC}, {1'b1, 4'h1});
    chk("cg_during", 32'(CLK_GATE_EN), 1);
    tick();
    chk("alu_en_off", 32'(ALU_EN), 0);
    ALU_OUT = 16'h000A; ALU_OUT_VLD = 1'b1;
    tick();
    ALU_OUT_VLD = 1'b0;
    chk("cg_off", 32'(CLK_GATE_EN), 0);
    tick();
    chk("alu_tx_lo", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h0A});
    tick();
    chk("alu_tx_hi", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h00});
    tick();
    chk("alu_tx_off", 32'(TX_D_VLD), 0);
    chk("alu_tx_count", 32'(tx_cnt), 2);

    // No-operand ALU op under TX back-pressure, result 0x1234
    TX_FULL = 1'b1;
    send(8'hDD);
    chk("nopr_cg", 32'(CLK_GATE_EN), 1);
    send(8'h00);
    chk("nopr_alu_en", {ALU_EN, ALU_FUNC}, {1'b1, 4'h0});
    ALU_OUT = 16'h1234; ALU_OUT_VLD = 1'b1;
    tick();
    ALU_OUT_VLD = 1'b0;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (TX_D_VLD) viol++;
    end
    chk("full_no_tx", 32'(viol), 0);
    TX_FULL = 1'b0;
    tick();
    chk("full_tx_lo", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h34});
    tick();
    chk("full_tx_hi", {TX_D_VLD, TX_P_DATA}, {1'b1, 8'h12});
    tick();
    chk("full_tx_off", 32'(TX_D_VLD), 0);

    // Unknown opcode dropped, then write 0x7F @ 3
    wr_cnt = 0;
    send(8'h55);
    tick();
    send(8'hAA); send(8'h03); send(8'h7F);
    chk("drop_wr", {RF_WR_EN, RF_ADDR, RF_WR_DATA}, {1'b1, 4'h3, 8'h7F});
    repeat (2) tick();
    chk("drop_wr_count", 32'(wr_cnt), 1);

    // Reset in the middle of an ALU frame
    send(8'hCC); send(8'h28);
    RST = 1'b0;
    #1;
    chk("midrst_outputs", {RF_WR_EN, RF_RD_EN, ALU_EN, TX_D_VLD, CLK_GATE_EN}, 0);
    chk("midrst_buses", {RF_ADDR, RF_WR_DATA, ALU_FUNC, TX_P_DATA}, 0);
    tick();
    RST = 1'b1;
    tick();
    send(8'hAA); send(8'h02); send(8'h11);
    chk("post_rst_wr", {RF_WR_EN, RF_ADDR, RF_WR_DATA}, {1'b1, 4'h2, 8'h11});
    chk("post_rst_cg", 32'(CLK_GATE_EN), 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
